// File: rtl/fifo_burst_packer.sv
// Drains a first-word-fall-through FIFO into framed valid/ready bursts with a last marker.
// A burst starts when BURST_LEN entries are present, or when a partial backlog has waited TIMEOUT cycles.
module fifo_burst_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BURST_LEN  = 8,
  parameter int TIMEOUT    = 16,
  parameter int LEN_W      = $clog2(BURST_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  input  logic                  fifo_empty_i,
  input  logic [ADDR_WIDTH:0]   fifo_count_i,
  output logic                  fifo_rd_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  output logic                  m_last_o,
  input  logic                  m_ready_i,
  output logic [LEN_W-1:0]      m_len_o,
  output logic                  busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int CNT_W     = ADDR_WIDTH + 1;
  localparam int TMR_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int TMR_MAX_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TMR_W-1:0] TMR_MAX    = TMR_W'(TMR_MAX_I);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(BURST_LEN);
  localparam logic [LEN_W-1:0] FULL_LEN   = LEN_W'(BURST_LEN);
  localparam bit               PARTIAL_EN = (TIMEOUT != 0);

  state_t           state;
  state_t           state_nxt;
  logic [TMR_W-1:0] timer;
  logic [LEN_W-1:0] fetch_left;
  logic [LEN_W-1:0] len_nxt;
  logic             start;
  logic             full_ok;
  logic             part_ok;
  logic             hs;

  function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] v);
    return (v == TMR_MAX) ? v : v + TMR_W'(1);
  endfunction

  // A zero count with a non-empty flag would start an endless zero-length burst, so it is excluded.
  assign full_ok = (fifo_count_i >= FULL_CNT);
  assign part_ok = PARTIAL_EN && !fifo_empty_i && (timer == TMR_MAX) && (fifo_count_i != '0);
  assign hs      = m_valid_o && m_ready_i;
  assign busy_o  = (state == RUN);

  assign fifo_rd_o = (state == RUN) && (fetch_left != '0) && !fifo_empty_i &&
                     (!m_valid_o || m_ready_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    len_nxt   = '0;
    case (state)
      IDLE: begin
        if (full_ok) begin
          start     = 1'b1;
          len_nxt   = FULL_LEN;
          state_nxt = RUN;
        end else if (part_ok) begin
          start     = 1'b1;
          len_nxt   = LEN_W'(fifo_count_i);
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (hs && m_last_o) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Idle-wait timer; held during RUN so every return to IDLE restarts the wait from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (state == IDLE) begin
      if (fifo_empty_i || start) begin
        timer <= '0;
      end else begin
        timer <= sat_inc(timer);
      end
    end
  end

  // Output stage: one beat register fed straight from the FIFO head on each pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_left <= '0;
      m_len_o    <= '0;
      m_data_o   <= '0;
      m_valid_o  <= 1'b0;
      m_last_o   <= 1'b0;
    end else begin
      if (start) begin
        m_len_o    <= len_nxt;
        fetch_left <= len_nxt;
      end else if (fifo_rd_o) begin
        fetch_left <= fetch_left - LEN_W'(1);
      end

      if (fifo_rd_o) begin
        m_data_o  <= fifo_data_i;
        m_valid_o <= 1'b1;
        m_last_o  <= (fetch_left == LEN_W'(1));
      end else if (hs) begin
        m_valid_o <= 1'b0;
        m_last_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_packer.sv
// Directed bench for fifo_burst_packer: behavioural FIFO source, beat monitor, immediate-assertion checks.
module tb_fifo_burst_packer;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int BL = 8;
  localparam int TO = 16;
  localparam int LW = $clog2(BL + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] fifo_data;
  logic          fifo_empty;
  logic [AW:0]   fifo_count;
  logic          fifo_rd;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready = 1'b1;
  logic [LW-1:0] m_len;
  logic          busy;

  always #5 clk = ~clk;

  fifo_burst_packer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .BURST_LEN (BL),
    .TIMEOUT   (TO),
    .LEN_W     (LW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fifo_data_i (fifo_data),
    .fifo_empty_i(fifo_empty),
    .fifo_count_i(fifo_count),
    .fifo_rd_o   (fifo_rd),
    .m_data_o    (m_data),
    .m_valid_o   (m_valid),
    .m_last_o    (m_last),
    .m_ready_i   (m_ready),
    .m_len_o     (m_len),
    .busy_o      (busy)
  );

  // FIFO source model (not affected by rst_n)
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW:0]   wp = '0;
  logic [AW:0]   rp = '0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          ld = 1'b0;
  logic [DW-1:0] ld_base = '0;
  int            ld_n = 0;

  assign fifo_count = wp - rp;
  assign fifo_empty = (wp == rp);
  assign fifo_data  = mem[rp[AW-1:0]];

  always @(posedge clk) begin
    if (fifo_rd) rp <= rp + 1'b1;
    if (wr_en) begin
      mem[wp[AW-1:0]] <= wr_data;
      wp <= wp + 1'b1;
    end else if (ld) begin
      for (int i = 0; i < ld_n; i++) mem[AW'(int'(wp) + i)] <= ld_base + DW'(i);
      wp <= wp + (AW+1)'(ld_n);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Beat monitor, sampled on the falling edge
  logic [DW-1:0] bd[$];
  logic          bl[$];
  int            blen[$];
  int            bc[$];
  logic          busy_h [0:8191];
  int            stall_pops = 0;
  int            bad_pops = 0;
  int            stab_err = 0;
  logic          pv = 1'b0;
  logic          pr = 1'b0;
  logic          pl = 1'b0;
  logic [DW-1:0] pd = '0;

  always @(negedge clk) begin
    if (cyc < 8192) busy_h[cyc] = busy;
    if (rst_n) begin
      if (m_valid && m_ready) begin
        bd.push_back(m_data);
        bl.push_back(m_last);
        blen.push_back(int'(m_len));
        bc.push_back(cyc);
      end
      if (m_valid && !m_ready && fifo_rd) stall_pops++;
      if (fifo_rd && (fifo_empty || !busy)) bad_pops++;
      if (pv && !pr && (!m_valid || m_data !== pd || m_last !== pl)) stab_err++;
    end
    pv = rst_n && m_valid;
    pr = m_ready;
    pd = m_data;
    pl = m_last;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_beats();
    bd.delete();
    bl.delete();
    blen.delete();
    bc.delete();
  endtask

  task automatic push_n(input logic [DW-1:0] base, input int n, output int cf, output int cl);
    cf = 0;
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + DW'(i);
      step();
      if (i == 0) cf = cyc;
    end
    cl    = cyc;
    wr_en = 1'b0;
  endtask

  task automatic load_n(input logic [DW-1:0] base, input int n, output int c);
    ld      = 1'b1;
    ld_base = base;
    ld_n    = n;
    step();
    ld = 1'b0;
    c  = cyc;
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    int k = 0;
    while (bd.size() < n && k < budget) begin
      step();
      k++;
    end
    chk({tag, "_nbeats"}, 64'(bd.size()), 64'(n));
  endtask

  // c0 < 0 skips the per-beat cycle check
  task automatic chk_beats(input string tag, input int idx, input int n, input logic [DW-1:0] base,
                           input int len, input int c0);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_data%0d", tag, i), 64'(bd[idx+i]), 64'(base + DW'(i)));
      chk($sformatf("%s_last%0d", tag, i), 64'(bl[idx+i]), 64'(i == len - 1));
      chk($sformatf("%s_len%0d", tag, i), 64'(blen[idx+i]), 64'(len));
      if (c0 >= 0) chk($sformatf("%s_cyc%0d", tag, i), 64'(bc[idx+i]), 64'(c0 + i));
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid"}, 64'(m_valid), 64'(0));
    chk({tag, "_last"},  64'(m_last),  64'(0));
    chk({tag, "_data"},  64'(m_data),  64'(0));
    chk({tag, "_len"},   64'(m_len),   64'(0));
    chk({tag, "_busy"},  64'(busy),    64'(0));
    chk({tag, "_rd"},    64'(fifo_rd), 64'(0));
  endtask

  initial begin
    int cf;
    int cl;
    int c;
    int r;

    rst_n   = 1'b0;
    m_ready = 1'b1;
    repeat (3) step();
    chk_outputs_zero("rst");
    rst_n = 1'b1;
    step();
    step();

    // Full burst of 8 as entries arrive one per cycle
    push_n(32'h10, 8, cf, cl);
    wait_beats(8, 40, "t1");
    step();
    step();
    chk_beats("t1", 0, 8, 32'h10, 8, cl + 2);
    chk("t1_busy_dec",  64'(busy_h[cl]),      64'(0));
    chk("t1_busy_run",  64'(busy_h[cl + 1]),  64'(1));
    chk("t1_busy_lastbeat", 64'(busy_h[cl + 9]), 64'(1));
    chk("t1_busy_fall", 64'(busy_h[cl + 10]), 64'(0));
    clear_beats();

    // Partial burst of 3 after the timeout
    push_n(32'hA0, 3, cf, cl);
    wait_beats(3, 40, "t2");
    step();
    step();
    chk_beats("t2", 0, 3, 32'hA0, 3, cf + 17);
    chk("t2_busy_dec", 64'(busy_h[cf + 15]), 64'(0));
    chk("t2_busy_run", 64'(busy_h[cf + 16]), 64'(1));
    clear_beats();

    // Single-entry burst: last on the only beat
    push_n(32'hC5, 1, cf, cl);
    wait_beats(1, 40, "tlen1");
    chk_beats("tlen1", 0, 1, 32'hC5, 1, cf + 17);
    step();
    clear_beats();

    // Backpressure pattern 1,0,0 repeating
    m_ready = 1'b0;
    push_n(32'h30, 8, cf, cl);
    for (int k = 0; k < 100 && bd.size() < 8; k++) begin
      m_ready = (k % 3 == 0);
      step();
    end
    m_ready = 1'b1;
    chk("t3_nbeats", 64'(bd.size()), 64'(8));
    chk_beats("t3", 0, 8, 32'h30, 8, -1);
    chk("t3_stall_pops", 64'(stall_pops), 64'(0));
    chk("t3_stable", 64'(stab_err), 64'(0));
    step();
    step();
    clear_beats();

    // Preloaded 20: two full bursts, then a partial of 4
    load_n(32'h40, 20, c);
    wait_beats(20, 80, "t4");
    chk_beats("t4a", 0, 8, 32'h40, 8, c + 2);
    chk_beats("t4b", 8, 8, 32'h48, 8, c + 12);
    chk_beats("t4c", 16, 4, 32'h50, 4, c + 37);
    step();
    step();
    clear_beats();

    // Completely full FIFO: four full bursts
    load_n(32'h60, 32, c);
    chk("t6_count_full", 64'(fifo_count), 64'(32));
    wait_beats(32, 80, "t6");
    for (int j = 0; j < 4; j++) begin
      chk_beats($sformatf("t6_b%0d", j), 8 * j, 8, 32'h60 + DW'(8 * j), 8, c + 2 + 10 * j);
    end
    step();
    step();
    clear_beats();

    // Reset after the third accepted beat
    load_n(32'h80, 8, c);
    wait_beats(3, 20, "t5pre");
    chk_beats("t5a", 0, 3, 32'h80, 8, c + 2);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("t5rst");
    step();
    step();
    rst_n = 1'b1;
    r = cyc;
    clear_beats();
    wait_beats(4, 60, "t5b");
    chk_beats("t5b", 0, 4, 32'h84, 4, r + 17);
    step();
    step();
    clear_beats();

    // Writes continue during a burst; length stays latched
    load_n(32'h90, 8, c);
    push_n(32'h98, 10, cf, cl);
    wait_beats(18, 80, "t7");
    chk_beats("t7a", 0, 8, 32'h90, 8, c + 2);
    chk_beats("t7b", 8, 8, 32'h98, 8, c + 12);
    chk_beats("t7c", 16, 2, 32'hA0, 2, c + 37);
    step();
    step();

    chk("glob_stall_pops", 64'(stall_pops), 64'(0));
    chk("glob_bad_pops",   64'(bad_pops),   64'(0));
    chk("glob_stable",     64'(stab_err),   64'(0));
    chk("glob_fifo_empty", 64'(fifo_empty), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_burst_packer.md
# fifo_burst_packer

Downstream consumer of a normal-type synchronous FIFO (first-word-fall-through head, pop-to-advance). Drains the FIFO into framed bursts on a valid/ready stream with a last marker. A burst starts when BURST_LEN entries are available, or when a partial amount has waited TIMEOUT cycles. It feeds DMA/packet stages that need bounded, length-tagged transfers.

## Interface
- DATA_WIDTH, 32, beat width; equals the FIFO data width
- ADDR_WIDTH, 5, FIFO address width; the FIFO occupancy input is ADDR_WIDTH+1 bits
- BURST_LEN, 8, maximum beats per burst; must satisfy 1 ≤ BURST_LEN ≤ 2**ADDR_WIDTH
- TIMEOUT, 16, consecutive non-empty idle cycles before a partial burst is forced; 0 disables partial bursts
- LEN_W, $clog2(BURST_LEN+1), width of m_len_o

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- fifo_data_i  in  DATA_WIDTH  FIFO head data, valid whenever fifo_empty_i=0
- fifo_empty_i  in  1  FIFO empty flag
- fifo_count_i  in  ADDR_WIDTH+1  FIFO occupancy
- fifo_rd_o  out  1  pop strobe, combinational, one entry per cycle high
- m_data_o  out  DATA_WIDTH  registered beat data
- m_valid_o  out  1  beat valid
- m_last_o  out  1  final beat of the burst
- m_ready_i  in  1  downstream ready
- m_len_o  out  LEN_W  length of the current burst; stable from the first beat to the last beat
- busy_o  out  1  high while state is RUN

## Operation
- FSM states: IDLE and RUN. Reset state is IDLE.
- IDLE, timer behaviour:
  - timer clears to 0 when fifo_empty_i=1.
  - Otherwise timer increments, saturating at TIMEOUT-1.
- IDLE, start conditions (full-burst condition has priority):
  - Full burst: fifo_count_i ≥ BURST_LEN → len=BURST_LEN.
  - Partial burst: TIMEOUT≠0, fifo_empty_i=0 and timer==TIMEOUT-1 → len=fifo_count_i.
- On start:
  - Latch len into m_len_o; load fetch_left=len and beat_left=len.
  - Clear timer; next state is RUN.
  - No pop occurs in the decision cycle.
- RUN, pop rule: fifo_rd_o = (fetch_left≠0) & ~fifo_empty_i & (~m_valid_o | m_ready_i).
- RUN, on pop:
  - m_data_o ← fifo_data_i and m_valid_o ← 1.
  - m_last_o ← (fetch_left==1).
  - fetch_left decrements.
- On handshake (m_valid_o & m_ready_i) with no pop in the same cycle: m_valid_o ← 0 and m_last_o ← 0.
- On handshake with m_last_o=1: next state is IDLE and busy_o falls.
- fifo_count_i and the timer are ignored during RUN. Writes arriving mid-burst never change len.
- Output register holds stable while m_valid_o=1 and m_ready_i=0. No pop occurs while stalled.
- Beats are never dropped or duplicated, and FIFO order is preserved.
- fifo_rd_o is never high while fifo_empty_i=1 or while in IDLE.

## Timing
- Reset values: m_valid_o=0, m_last_o=0, m_data_o=0, m_len_o=0, busy_o=0, fifo_rd_o=0, timer=0, state=IDLE.
- Full-burst latency: decision cycle t → first pop at t+1 → m_valid_o=1 at t+2.
- Throughput: one beat per cycle when m_ready_i=1 and the FIFO holds the latched entries.
- A burst of N beats with ready held high occupies RUN for N+1 cycles.
- Minimum one IDLE cycle between bursts, so back-to-back full bursts have a 2-cycle gap.
- Partial burst: the first non-empty IDLE cycle is timer=0. The burst starts in the TIMEOUT-th consecutive non-empty IDLE cycle; the first beat is valid 2 cycles later.
- Reset mid-burst:
  - All outputs clear asynchronously and the FSM returns to IDLE.
  - Entries already popped are lost. Unpopped entries remain in the FIFO and form the next burst.
- Boundary at len=1: m_last_o is high on the only beat.
- Boundary at fifo_count_i = 2**ADDR_WIDTH (full FIFO): a full burst of BURST_LEN starts.

## Test plan
- Write 8 entries 0x10..0x17, m_ready_i=1 → burst starts the cycle count hits 8; 8 consecutive beats 0x10..0x17; m_last_o on 0x17; m_len_o=8; busy_o falls after the last handshake.
- Write 3 entries 0xA0..0xA2 then stop, TIMEOUT=16 → burst starts 16 non-empty cycles after the first entry; m_len_o=3; m_last_o on 0xA2.
- Full burst with m_ready_i toggling 1,0,0,1,... → m_data_o stable while stalled; no fifo_rd_o during stalls; all 8 beats delivered in order exactly once.
- Preload 20 entries → bursts of 8 and 8 separated by 2-cycle gaps, then a partial burst of 4 after timeout, with m_last_o on every burst end.
- Assert rst_n low after the 3rd beat of an 8-beat burst → outputs 0 immediately; after release, the next burst begins from the first unpopped entry.
- Write continuously during a burst of 8 → m_len_o stays 8; the next burst starts after the IDLE decision cycle using the new count.
